// File: rtl/wall_clock_core_pkg.sv
// Shared constants and display helpers for the wall-clock time-of-day engine.
package wall_clock_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    localparam int BTN_MIN = 0;
    localparam int BTN_HR  = 1;
    localparam int BTN_RUN = 2;
    localparam int NUM_BTN = 3;

    function automatic logic [7:0] binToBcd(input logic [5:0] value);
        return {4'(value / 6'd10), 4'(value % 6'd10)};
    endfunction

    // 12 h mode shows midnight/noon as 12 and folds the afternoon back onto 1..11.
    function automatic logic [4:0] displayHour(input logic [4:0] hour, input logic mode24);
        logic [4:0] result;
        if (mode24)
            result = hour;
        else if (hour == 5'd0)
            result = 5'd12;
        else if (hour > 5'd12)
            result = hour - 5'd12;
        else
            result = hour;
        return result;
    endfunction

endpackage

// File: rtl/wall_clock_core_if.sv
// Button inputs and display outputs between the time engine and its neighbours.
interface wall_clock_core_if;
    import wall_clock_pkg::*;

    logic [NUM_BTN-1:0] button;
    logic [3:0]         hr_l;
    logic [3:0]         hr_r;
    logic [3:0]         min_l;
    logic [3:0]         min_r;
    logic [5:0]         sec;
    logic               colon;
    logic               pm;
    logic               running;

    modport master (
        output button,
        input  hr_l, hr_r, min_l, min_r, sec, colon, pm, running
    );

    modport slave (
        input  button,
        output hr_l, hr_r, min_l, min_r, sec, colon, pm, running
    );

endinterface

// File: rtl/wall_clock_core_button_debouncer.sv
// One button channel: 2-FF synchroniser, stability counter and a pulse on each
// accepted 0->1 transition.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_count;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_count == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Any sample that agrees with the accepted level restarts the stability run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_pulse <= w_accept && r_sync2;
            if (w_accept) begin
                r_level <= r_sync2;
                r_count <= '0;
            end else if (w_differs) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= '0;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/wall_clock_core.sv
// Time-of-day engine: 1 Hz prescaler, hh:mm:ss counters, button set/run control
// and BCD decode for the seven-segment driver.
module wall_clock_core
    import wall_clock_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MODE_24H        = 1
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    wall_clock_core_if.slave  bus
);

    localparam int                 PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(CLK_HZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_HZ / 2);
    localparam logic               IS_24H     = (MODE_24H != 0);

    logic [NUM_BTN-1:0] w_btnPulse;
    logic               w_minPulse;
    logic               w_hrPulse;
    logic               w_runPulse;
    logic               w_setPulse;
    logic               w_secTick;
    logic [PRESC_W-1:0] r_presc;
    logic [5:0]         r_sec;
    logic [5:0]         r_min;
    logic [4:0]         r_hour;
    logic               r_running;
    logic [4:0]         w_dispHour;
    logic [7:0]         w_hourBcd;
    logic [7:0]         w_minBcd;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gen_debounce
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .i_clk   (CLK100MHZ),
            .i_rst   (reset),
            .i_button(bus.button[g]),
            .o_pulse (w_btnPulse[g])
        );
    end

    assign w_minPulse = w_btnPulse[BTN_MIN];
    assign w_hrPulse  = w_btnPulse[BTN_HR];
    assign w_runPulse = w_btnPulse[BTN_RUN];
    assign w_setPulse = w_minPulse || w_hrPulse;
    assign w_secTick  = r_running && (r_presc == PRESC_MAX);

    // A minute set restarts the current second so the display lands on :00 cleanly.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            r_presc <= '0;
        else if (!r_running || w_minPulse || w_secTick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset)
            r_running <= 1'b1;
        else if (w_runPulse)
            r_running <= ~r_running;
    end

    // Set pulses win over a coincident tick; the tick and its carries are dropped.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
        end else if (w_setPulse) begin
            if (w_minPulse) begin
                r_min <= (r_min == MIN_MAX) ? '0 : r_min + 1'b1;
                r_sec <= '0;
            end
            if (w_hrPulse)
                r_hour <= (r_hour == HOUR_MAX) ? '0 : r_hour + 1'b1;
        end else if (w_secTick) begin
            if (r_sec == SEC_MAX) begin
                r_sec <= '0;
                if (r_min == MIN_MAX) begin
                    r_min  <= '0;
                    r_hour <= (r_hour == HOUR_MAX) ? '0 : r_hour + 1'b1;
                end else begin
                    r_min <= r_min + 1'b1;
                end
            end else begin
                r_sec <= r_sec + 1'b1;
            end
        end
    end

    assign w_dispHour  = displayHour(r_hour, IS_24H);
    assign w_hourBcd   = binToBcd({1'b0, w_dispHour});
    assign w_minBcd    = binToBcd(r_min);

    assign bus.hr_l    = w_hourBcd[7:4];
    assign bus.hr_r    = w_hourBcd[3:0];
    assign bus.min_l   = w_minBcd[7:4];
    assign bus.min_r   = w_minBcd[3:0];
    assign bus.sec     = r_sec;
    assign bus.colon   = !r_running || (r_presc < PRESC_HALF);
    assign bus.pm      = !IS_24H && (r_hour >= 5'd12);
    assign bus.running = r_running;

endmodule

// File: tb/tb_wall_clock_core.sv
// Directed bench for wall_clock_core with a fast clock (10 cycles per second) and
// short debounce; one 24 h instance and one 12 h instance share clock and reset.
module tb_wall_clock_core;
    import wall_clock_pkg::*;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;

    typedef struct {
        int pressIdx;
        int expHrL;
        int expHrR;
        int expPm;
    } hourVec_t;

    logic     clk   = 1'b0;
    logic     reset = 1'b1;
    int       nCompared   = 0;
    int       nMismatched = 0;
    hourVec_t hourVecs[24];

    wall_clock_core_if bus24();
    wall_clock_core_if bus12();

    wall_clock_core #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .MODE_24H(1)
    ) dut24 (
        .CLK100MHZ(clk), .reset(reset), .bus(bus24)
    );

    wall_clock_core #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .MODE_24H(0)
    ) dut12 (
        .CLK100MHZ(clk), .reset(reset), .bus(bus12)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkTime(input string tag, input int hl, input int hr, input int ml,
                             input int mr, input int s);
        checkOutput($sformatf("%s hr_l", tag), bus24.hr_l, hl);
        checkOutput($sformatf("%s hr_r", tag), bus24.hr_r, hr);
        checkOutput($sformatf("%s min_l", tag), bus24.min_l, ml);
        checkOutput($sformatf("%s min_r", tag), bus24.min_r, mr);
        checkOutput($sformatf("%s sec", tag), bus24.sec, s);
    endtask

    task automatic setBtn(input bit on12, input int idx, input logic val);
        if (on12)
            bus12.button[idx] = val;
        else
            bus24.button[idx] = val;
    endtask

    // Clean press: held long enough to be accepted, then released and allowed to settle.
    task automatic applyStimulus(input bit on12, input int idx, input int holdCycles);
        setBtn(on12, idx, 1'b1);
        repeat (holdCycles) @(negedge clk);
        setBtn(on12, idx, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    // Stops on the first negedge showing sec=59, i.e. just after that tick.
    task automatic waitSec59(input string tag);
        int found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            @(negedge clk);
            if (bus24.sec == 6'd59)
                found = 1;
        end
        checkOutput($sformatf("%s reach sec 59", tag), found, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hourVecs[0]  = '{-1,     1, 2, 0};
        hourVecs[1]  = '{BTN_HR, 0, 1, 0};
        hourVecs[2]  = '{BTN_HR, 0, 2, 0};
        hourVecs[3]  = '{BTN_HR, 0, 3, 0};
        hourVecs[4]  = '{BTN_HR, 0, 4, 0};
        hourVecs[5]  = '{BTN_HR, 0, 5, 0};
        hourVecs[6]  = '{BTN_HR, 0, 6, 0};
        hourVecs[7]  = '{BTN_HR, 0, 7, 0};
        hourVecs[8]  = '{BTN_HR, 0, 8, 0};
        hourVecs[9]  = '{BTN_HR, 0, 9, 0};
        hourVecs[10] = '{BTN_HR, 1, 0, 0};
        hourVecs[11] = '{BTN_HR, 1, 1, 0};
        hourVecs[12] = '{BTN_HR, 1, 2, 1};
        hourVecs[13] = '{BTN_HR, 0, 1, 1};
        hourVecs[14] = '{BTN_HR, 0, 2, 1};
        hourVecs[15] = '{BTN_HR, 0, 3, 1};
        hourVecs[16] = '{BTN_HR, 0, 4, 1};
        hourVecs[17] = '{BTN_HR, 0, 5, 1};
        hourVecs[18] = '{BTN_HR, 0, 6, 1};
        hourVecs[19] = '{BTN_HR, 0, 7, 1};
        hourVecs[20] = '{BTN_HR, 0, 8, 1};
        hourVecs[21] = '{BTN_HR, 0, 9, 1};
        hourVecs[22] = '{BTN_HR, 1, 0, 1};
        hourVecs[23] = '{BTN_HR, 1, 1, 1};

        bus24.button = '0;
        bus12.button = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkTime("reset24", 0, 0, 0, 0, 0);
        checkOutput("reset24 colon", bus24.colon, 1);
        checkOutput("reset24 pm", bus24.pm, 0);
        checkOutput("reset24 running", bus24.running, 1);
        checkOutput("reset12 hr_l", bus12.hr_l, 1);
        checkOutput("reset12 hr_r", bus12.hr_r, 2);
        checkOutput("reset12 pm", bus12.pm, 0);

        $display("[TB] free run for 600 cycles");
        reset = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            checkOutput($sformatf("colon k=%0d", k), bus24.colon, (k < 5) ? 1 : 0);
        end
        repeat (591) @(negedge clk);
        checkTime("one minute", 0, 0, 0, 1, 0);

        $display("[TB] glitch rejection and debounce latency");
        setBtn(0, BTN_MIN, 1'b1);
        repeat (2) @(negedge clk);
        setBtn(0, BTN_MIN, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("glitch min_r", bus24.min_r, 1);
        setBtn(0, BTN_MIN, 1'b1);
        repeat (6) @(negedge clk);
        checkOutput("edge+6 min_r", bus24.min_r, 1);
        @(negedge clk);
        checkOutput("edge+7 min_r", bus24.min_r, 2);
        checkOutput("edge+7 sec", bus24.sec, 0);
        repeat (3) @(negedge clk);
        setBtn(0, BTN_MIN, 1'b0);
        repeat (12) @(negedge clk);
        checkOutput("single step min_r", bus24.min_r, 2);

        $display("[TB] set 23:59 in hold, then roll over midnight");
        applyStimulus(0, BTN_RUN, 10);
        checkOutput("hold running", bus24.running, 0);
        checkOutput("hold colon", bus24.colon, 1);
        repeat (57) applyStimulus(0, BTN_MIN, 10);
        repeat (23) applyStimulus(0, BTN_HR, 10);
        checkTime("set 23:59", 2, 3, 5, 9, 0);
        checkOutput("24h pm at 23", bus24.pm, 0);
        applyStimulus(0, BTN_RUN, 10);
        checkOutput("resume running", bus24.running, 1);
        waitSec59("midnight");
        repeat (9) @(negedge clk);
        checkTime("before wrap", 2, 3, 5, 9, 59);
        @(negedge clk);
        checkTime("midnight wrap", 0, 0, 0, 0, 0);

        $display("[TB] run/hold toggle");
        setBtn(0, BTN_RUN, 1'b1);
        repeat (6) @(negedge clk);
        checkOutput("pre-hold running", bus24.running, 1);
        @(negedge clk);
        checkOutput("enter hold running", bus24.running, 0);
        setBtn(0, BTN_RUN, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checkOutput($sformatf("hold colon k=%0d", k), bus24.colon, 1);
            checkOutput($sformatf("hold sec k=%0d", k), bus24.sec, 0);
        end
        setBtn(0, BTN_RUN, 1'b1);
        repeat (7) @(negedge clk);
        checkOutput("leave hold running", bus24.running, 1);
        checkOutput("leave hold sec", bus24.sec, 0);
        setBtn(0, BTN_RUN, 1'b0);
        repeat (12) @(negedge clk);

        $display("[TB] minute set coincident with tick at 00:05:59");
        applyStimulus(0, BTN_RUN, 10);
        repeat (5) applyStimulus(0, BTN_MIN, 10);
        checkTime("set 00:05", 0, 0, 0, 5, 0);
        applyStimulus(0, BTN_RUN, 10);
        waitSec59("min align");
        repeat (3) @(negedge clk);
        setBtn(0, BTN_MIN, 1'b1);
        repeat (6) @(negedge clk);
        checkTime("min align before", 0, 0, 0, 5, 59);
        @(negedge clk);
        checkTime("min align after", 0, 0, 0, 6, 0);
        setBtn(0, BTN_MIN, 1'b0);
        repeat (12) @(negedge clk);

        $display("[TB] hour set coincident with tick at 00:06:59");
        waitSec59("hr align");
        repeat (3) @(negedge clk);
        setBtn(0, BTN_HR, 1'b1);
        repeat (6) @(negedge clk);
        checkTime("hr align before", 0, 0, 0, 6, 59);
        @(negedge clk);
        checkTime("hr align after", 0, 1, 0, 6, 59);
        setBtn(0, BTN_HR, 1'b0);
        repeat (12) @(negedge clk);

        $display("[TB] 12 h hour stepping");
        for (int i = 0; i < 24; i++) begin
            if (hourVecs[i].pressIdx >= 0)
                applyStimulus(1, hourVecs[i].pressIdx, 10);
            checkOutput($sformatf("12h step %0d hr_l", i), bus12.hr_l, hourVecs[i].expHrL);
            checkOutput($sformatf("12h step %0d hr_r", i), bus12.hr_r, hourVecs[i].expHrR);
            checkOutput($sformatf("12h step %0d pm", i), bus12.pm, hourVecs[i].expPm);
        end

        $display("[TB] reset mid-second and mid-debounce");
        setBtn(0, BTN_MIN, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkTime("async reset", 0, 0, 0, 0, 0);
        checkOutput("async reset colon", bus24.colon, 1);
        checkOutput("async reset running", bus24.running, 1);
        checkOutput("async reset 12h hr_l", bus12.hr_l, 1);
        checkOutput("async reset 12h hr_r", bus12.hr_r, 2);
        checkOutput("async reset 12h pm", bus12.pm, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("post reset edge+6 min_r", bus24.min_r, 0);
        @(negedge clk);
        checkOutput("post reset edge+7 min_r", bus24.min_r, 1);
        setBtn(0, BTN_MIN, 1'b0);
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
